// File: rtl/profibus_uart_pkg.sv
// Shared PROFIBUS UART definitions: receiver states, character geometry, parity sense.
// Used by the RX deserializer and intended for the TX serializer as well.
package profibus_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int   UART_DATA_BITS = 8;
   localparam int   UART_CHAR_BITS = 11;
   localparam logic PARITY_EVEN    = 1'b0;

   // True when data plus parity bit do not add up to the configured parity sense.
   function automatic logic parity_mismatch(input logic [UART_DATA_BITS-1:0] data,
                                            input logic                      par);
      return ((^data) ^ par) != PARITY_EVEN;
   endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period timer: loads half a bit on start, then ticks once per bit while run is high.
// Latency: tick on the nominal sample cycle (one cycle later, with a 2-of-3 vote, under PROFIBUS_UART_RX_MAJORITY_EN).
module uart_rx_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   input  logic rx,
   output logic tick,
   output logic sample
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LOAD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LOAD_BIT  = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;
   logic          at_point;

   assign at_point = run && (cnt == '0);

   // Down-counter reaching zero marks a sample point, then reloads a full bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= LOAD_HALF;
      end else if (run) begin
         if (at_point) begin
            cnt <= LOAD_BIT;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

`ifdef PROFIBUS_UART_RX_MAJORITY_EN
   logic [1:0] hist;
   logic       at_point_q;

   // hist[1] = rx at s-1, hist[0] = rx at s; current rx is s+1 when at_point_q fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist       <= 2'b11;
         at_point_q <= 1'b0;
      end else begin
         hist       <= {hist[0], rx};
         at_point_q <= at_point;
      end
   end

   assign tick   = at_point_q;
   assign sample = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
`else
   assign tick   = at_point;
   assign sample = rx;
`endif

endmodule

// File: rtl/profibus_uart_rx.sv
// PROFIBUS UART receive deserializer: 11-bit characters (start, 8 data LSB first, even parity, stop).
// Latency T0 -> rx_valid: HALF+10*CLKS_PER_BIT+1 (+1 with PROFIBUS_UART_RX_MAJORITY_EN). No backpressure: rx_valid is a strobe.
module profibus_uart_rx
   import profibus_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_falling,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       busy
);

   rx_state_t                 state;
   rx_state_t                 state_nxt;
   logic                      tick;
   logic                      bit_val;
   logic                      timer_start;
   logic                      shift_en;
   logic                      par_load;
   logic                      done;
   logic [UART_DATA_BITS-1:0] shreg;
   logic [2:0]                idx;
   logic                      par_err;

   assign busy = (state != ST_IDLE);

   uart_rx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (timer_start),
      .run    (busy),
      .rx     (rx),
      .tick   (tick),
      .sample (bit_val)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_start = 1'b0;
      shift_en    = 1'b0;
      par_load    = 1'b0;
      done        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_falling) begin
               timer_start = 1'b1;
               state_nxt   = ST_START;
            end
         end
         ST_START: begin
            // A high start sample is a glitch: drop back silently.
            if (tick) begin
               state_nxt = bit_val ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               if (idx == 3'(UART_DATA_BITS - 1)) begin
                  state_nxt = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               par_load  = 1'b1;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            // Back to IDLE right after the stop sample so an early next start edge is caught.
            if (tick) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg         <= '0;
         idx           <= '0;
         par_err       <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_valid <= done;
         if (timer_start) begin
            idx <= '0;
         end else if (shift_en) begin
            shreg <= {bit_val, shreg[UART_DATA_BITS-1:1]};
            idx   <= idx + 3'd1;
         end
         if (par_load) begin
            par_err <= parity_mismatch(shreg, bit_val);
         end
         if (done) begin
            rx_data       <= shreg;
            rx_parity_err <= par_err;
            rx_frame_err  <= ~bit_val;
         end
      end
   end

endmodule

// File: tb/tb_profibus_uart_rx.sv
// Randomized scoreboard bench for profibus_uart_rx with CLKS_PER_BIT=16.
module tb_profibus_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef PROFIBUS_UART_RX_MAJORITY_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT = HALF + 10 * CPB + 1 + EXTRA;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_falling = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       busy;

   profibus_uart_rx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .rx_falling    (rx_falling),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n = cyc_n + 1;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         t;
   } exp_t;

   exp_t       sbq[$];
   exp_t       mon_e;
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] last_data = 8'h00;
   logic       last_fe = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      vectors = vectors + 1;
      if (act != exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc_n);
      end
   endtask

   // Monitor: every rx_valid strobe must match the oldest expected character.
   always @(negedge clk) begin
      if (rx_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected rx_valid", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            check("rx_data", int'(rx_data), int'(mon_e.d));
            check("rx_parity_err", int'(rx_parity_err), int'(mon_e.pe));
            check("rx_frame_err", int'(rx_frame_err), int'(mon_e.fe));
            check("rx_valid latency", cyc_n, mon_e.t);
            last_data = mon_e.d;
            last_fe   = mon_e.fe;
         end
      end
   end

   // One line cycle: inputs change just after the rising edge.
   task automatic drive(input logic v);
      rx_falling = rx & ~v;
      rx         = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1);
   endtask

   // Sends one character; abort_at >= 0 pulses rst at that cycle offset from T0.
   task automatic send(input logic [7:0] d, input logic par, input logic stop, input int abort_at);
      logic [10:0] bits;
      int          t0;
      exp_t        e;
      bits = {stop, par, d, 1'b0};
      t0   = cyc_n;
      if (abort_at < 0) begin
         e.d  = d;
         e.pe = (($countones(d) + int'(par)) % 2) != 0;
         e.fe = (stop == 1'b0);
         e.t  = t0 + LAT;
         sbq.push_back(e);
      end
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < CPB; c++) begin
            if (b * CPB + c == abort_at) begin
               rst = 1'b1;
               drive(bits[b]);
               rst = 1'b0;
               last_data = 8'h00;
               last_fe   = 1'b0;
               @(negedge clk);
               check("busy after abort", int'(busy), 0);
               check("rx_valid after abort", int'(rx_valid), 0);
               check("rx_data after abort", int'(rx_data), 0);
               drive(1'b1);
               return;
            end
            drive(bits[b]);
         end
      end
   endtask

   // Short low pulse that must be rejected at the start-bit sample.
   task automatic glitch(input int len);
      int t0;
      t0 = cyc_n;
      drive(1'b0);
      @(negedge clk);
      check("busy at T0+1", int'(busy), 1);
      for (int i = 1; i < len; i++) drive(1'b0);
      while (cyc_n < t0 + 9 + EXTRA) drive(1'b1);
      @(negedge clk);
      check("busy after glitch", int'(busy), 0);
      check("rx_data hold after glitch", int'(rx_data), int'(last_data));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d expected characters outstanding", sbq.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      logic       par;
      logic       stop;

      rst = 1'b1;
      repeat (3) drive(1'b1);
      @(negedge clk);
      check("reset rx_data", int'(rx_data), 0);
      check("reset rx_valid", int'(rx_valid), 0);
      check("reset rx_parity_err", int'(rx_parity_err), 0);
      check("reset rx_frame_err", int'(rx_frame_err), 0);
      check("reset busy", int'(busy), 0);
      rst = 1'b0;
      idle(4);

      // Clean, then parity error, back to back.
      send(8'h5A, 1'b0, 1'b1, -1);
      send(8'h5A, 1'b1, 1'b1, -1);
      idle(3);

      // Frame error with the line stuck low afterwards: must not retrigger.
      send(8'hFF, 1'b0, 1'b0, -1);
      repeat (40) drive(1'b0);
      @(negedge clk);
      check("busy while line held low", int'(busy), 0);
      check("rx_frame_err hold", int'(rx_frame_err), 1);
      check("rx_data hold after frame err", int'(rx_data), int'(last_data));
      idle(5);

      glitch(3);
      idle(3);

      // Second start edge 8 cycles after the first stop sample.
      send(8'h01, 1'b1, 1'b1, -1);
      send(8'h80, 1'b1, 1'b1, -1);
      idle(5);

      // Reset during data bit 4, then a clean character.
      send(8'hAA, 1'b0, 1'b1, 5 * CPB + 5);
      idle(5);
      send(8'hC3, 1'b0, 1'b1, -1);
      idle(2);

      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            glitch(int'($urandom_range(1, 6)));
            idle(int'($urandom_range(0, 4)));
         end else begin
            d    = 8'($urandom);
            par  = (($countones(d) % 2) != 0) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send(d, par, stop, -1);
            if (!stop) idle(int'($urandom_range(1, 12)));
            else       idle(int'($urandom_range(0, 12)));
         end
      end

      idle(30);
      check("scoreboard drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
